// File: rtl/match_log_pkg.sv
// Shared defaults and helpers for the match event logger and its timestamp FIFO.
package match_log_pkg;

  localparam int DEF_DEPTH = 4;
  localparam int DEF_TS_W  = 16;
  localparam int DEF_CNT_W = 16;

  // Wrapping pointer width: one extra bit beyond the address distinguishes full from empty.
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/ts_fifo.sv
// Show-ahead timestamp FIFO with wrapping pointers and a synchronous clear.
// A push into a full FIFO is accepted only when a pop frees a slot in the same cycle.
module ts_fifo
  import match_log_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int W     = DEF_TS_W
) (
  input  logic         clk,
  input  logic         nrst,
  input  logic         clr,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         empty,
  output logic         full
);

  localparam int PW = ptr_w(DEPTH);
  localparam int AW = PW - 1;
  localparam logic [PW-1:0] PTR_ONE = {{(PW-1){1'b0}}, 1'b1};

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic          do_pop;
  logic          do_push;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

  // Next-state for pointers and storage; clear empties the FIFO and ignores push/pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    for (int i = 0; i < DEPTH; i++) mem_d[i] = mem_q[i];
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q[AW-1:0]] = din;
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end
      if (do_pop) rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
  end

  // Pointer and storage registers.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
    end
  end

endmodule

// File: rtl/match_event_logger.sv
// Counts rising edges of match_in, logs their timestamps in a FIFO, and raises a
// sticky alarm once the count reaches a programmable threshold.
module match_event_logger
  import match_log_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int TS_W  = DEF_TS_W,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             match_in,
  input  logic             clr,
  input  logic [CNT_W-1:0] threshold,
  input  logic             rd_en,
  output logic [TS_W-1:0]  ts_data,
  output logic             ts_valid,
  output logic             fifo_full,
  output logic [CNT_W-1:0] match_count,
  output logic             alarm,
  output logic             overflow
);

  localparam logic [TS_W-1:0]  TS_ONE  = {{(TS_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic             match_dly_q, match_dly_d;
  logic [TS_W-1:0]  ts_q, ts_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             alarm_q, alarm_d;
  logic             ovf_q, ovf_d;
  logic             evt;
  logic             push;
  logic             pop;
  logic             fifo_empty;

  // A held-high match flag is one event; clear swallows any same-cycle event or read.
  assign evt  = match_in & ~match_dly_q;
  assign push = evt & ~clr;
  assign pop  = rd_en & ~clr;

  ts_fifo #(
    .DEPTH (DEPTH),
    .W     (TS_W)
  ) u_fifo (
    .clk   (clk),
    .nrst  (nrst),
    .clr   (clr),
    .push  (push),
    .pop   (pop),
    .din   (ts_q),
    .dout  (ts_data),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  assign ts_valid    = ~fifo_empty;
  assign match_count = count_q;
  assign alarm       = alarm_q;
  assign overflow    = ovf_q;

  // Next-state for edge detect, free-running timestamp, saturating count, alarm and overflow.
  always_comb begin
    match_dly_d = match_in;
    ts_d        = ts_q + TS_ONE;
    count_d     = count_q;
    alarm_d     = alarm_q;
    ovf_d       = ovf_q;
    if (clr) begin
      count_d = '0;
      alarm_d = 1'b0;
      ovf_d   = 1'b0;
    end else begin
      if (evt && (count_q != {CNT_W{1'b1}})) count_d = count_q + CNT_ONE;
      // Alarm latches against the upcoming count and ignores later threshold changes.
      if ((threshold != '0) && (count_d >= threshold)) alarm_d = 1'b1;
      // Full FIFO always has data, so a same-cycle read frees the slot for the push.
      if (push && fifo_full && !pop) ovf_d = 1'b1;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      match_dly_q <= 1'b0;
      ts_q        <= '0;
      count_q     <= '0;
      alarm_q     <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      match_dly_q <= match_dly_d;
      ts_q        <= ts_d;
      count_q     <= count_d;
      alarm_q     <= alarm_d;
      ovf_q       <= ovf_d;
    end
  end

endmodule

// File: tb/tb_match_event_logger.sv
// Directed bench for match_event_logger with DEPTH=4, TS_W=16, CNT_W=16.
// cyc tracks the timestamp value the DUT holds during the current cycle.
module tb_match_event_logger;

  logic        clk;
  logic        nrst;
  logic        match_in;
  logic        clr;
  logic [15:0] threshold;
  logic        rd_en;
  logic [15:0] ts_data;
  logic        ts_valid;
  logic        fifo_full;
  logic [15:0] match_count;
  logic        alarm;
  logic        overflow;

  int nchk  = 0;
  int npass = 0;
  int cyc   = 0;

  match_event_logger #(.DEPTH(4), .TS_W(16), .CNT_W(16)) dut (
    .clk         (clk),
    .nrst        (nrst),
    .match_in    (match_in),
    .clr         (clr),
    .threshold   (threshold),
    .rd_en       (rd_en),
    .ts_data     (ts_data),
    .ts_valid    (ts_valid),
    .fifo_full   (fifo_full),
    .match_count (match_count),
    .alarm       (alarm),
    .overflow    (overflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    assert (got === exp) npass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) tick();
  endtask

  task automatic pulse(input int c);
    wait_to(c);
    match_in = 1'b1;
    tick();
    match_in = 1'b0;
  endtask

  task automatic pop_chk(input string tag, input int exp);
    check(tag, {16'h0, ts_data}, exp);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
  endtask

  task automatic do_reset();
    nrst      = 1'b0;
    match_in  = 1'b0;
    clr       = 1'b0;
    rd_en     = 1'b0;
    threshold = 16'd0;
    tick();
    tick();
    nrst = 1'b1;
    cyc  = 0;
  endtask

  initial begin
    nrst = 1'b0; match_in = 1'b0; clr = 1'b0; rd_en = 1'b0; threshold = 16'd0;
    #2;
    // Reset state
    check("rst_ts_valid", {31'h0, ts_valid}, 0);
    check("rst_ts_data", {16'h0, ts_data}, 0);
    check("rst_full", {31'h0, fifo_full}, 0);
    check("rst_count", {16'h0, match_count}, 0);
    check("rst_alarm", {31'h0, alarm}, 0);
    check("rst_overflow", {31'h0, overflow}, 0);

    // Pulses at cycles 5, 9, 13
    do_reset();
    pulse(5);
    check("t1_count1", {16'h0, match_count}, 1);
    check("t1_valid1", {31'h0, ts_valid}, 1);
    pulse(9);
    pulse(13);
    check("t1_count3", {16'h0, match_count}, 3);
    pop_chk("t1_pop0", 5);
    pop_chk("t1_pop1", 9);
    pop_chk("t1_pop2", 13);
    check("t1_empty", {31'h0, ts_valid}, 0);
    check("t1_empty_data", {16'h0, ts_data}, 0);
    rd_en = 1'b1; tick(); rd_en = 1'b0;
    check("t1_underflow", {31'h0, ts_valid}, 0);

    // Held high for 10 cycles, with a read on the first (empty) cycle
    do_reset();
    wait_to(2);
    match_in = 1'b1;
    rd_en    = 1'b1;
    tick();
    rd_en = 1'b0;
    check("t2_push_pop_empty", {31'h0, ts_valid}, 1);
    check("t2_data", {16'h0, ts_data}, 2);
    repeat (9) tick();
    match_in = 1'b0;
    tick();
    check("t2_count", {16'h0, match_count}, 1);
    pop_chk("t2_pop", 2);
    check("t2_one_entry", {31'h0, ts_valid}, 0);

    // Six events, no reads
    do_reset();
    pulse(1); pulse(3); pulse(5); pulse(7);
    check("t3_full4", {31'h0, fifo_full}, 1);
    check("t3_ovf4", {31'h0, overflow}, 0);
    pulse(9);
    check("t3_ovf5", {31'h0, overflow}, 1);
    pulse(11);
    check("t3_count", {16'h0, match_count}, 6);
    check("t3_full6", {31'h0, fifo_full}, 1);
    check("t3_alarm_off", {31'h0, alarm}, 0);
    pop_chk("t3_pop0", 1);
    check("t3_ovf_sticky", {31'h0, overflow}, 1);
    check("t3_not_full", {31'h0, fifo_full}, 0);
    pop_chk("t3_pop1", 3);
    pop_chk("t3_pop2", 5);
    pop_chk("t3_pop3", 7);
    check("t3_empty", {31'h0, ts_valid}, 0);

    // Full FIFO, event and read together
    do_reset();
    pulse(1); pulse(3); pulse(5); pulse(7);
    wait_to(9);
    match_in = 1'b1;
    rd_en    = 1'b1;
    tick();
    match_in = 1'b0;
    rd_en    = 1'b0;
    check("t4_full", {31'h0, fifo_full}, 1);
    check("t4_ovf", {31'h0, overflow}, 0);
    check("t4_count", {16'h0, match_count}, 5);
    pop_chk("t4_pop0", 3);
    pop_chk("t4_pop1", 5);
    pop_chk("t4_pop2", 7);
    pop_chk("t4_pop3", 9);
    check("t4_empty", {31'h0, ts_valid}, 0);

    // Alarm at threshold 3, then clear racing an event
    do_reset();
    threshold = 16'd3;
    pulse(2);
    pulse(4);
    check("t5_alarm_early", {31'h0, alarm}, 0);
    pulse(6);
    check("t5_alarm", {31'h0, alarm}, 1);
    check("t5_count3", {16'h0, match_count}, 3);
    threshold = 16'd10;
    tick();
    check("t5_alarm_hold", {31'h0, alarm}, 1);
    clr      = 1'b1;
    match_in = 1'b1;
    tick();
    clr      = 1'b0;
    match_in = 1'b0;
    check("t5_clr_count", {16'h0, match_count}, 0);
    check("t5_clr_alarm", {31'h0, alarm}, 0);
    check("t5_clr_valid", {31'h0, ts_valid}, 0);
    pulse(12);
    check("t5_ts_not_cleared", {16'h0, ts_data}, 12);
    check("t5_count_after", {16'h0, match_count}, 1);

    // Reset with two entries queued
    do_reset();
    pulse(1);
    pulse(3);
    check("t6_queued", {31'h0, ts_valid}, 1);
    nrst = 1'b0;
    #1;
    check("t6_rst_valid", {31'h0, ts_valid}, 0);
    check("t6_rst_data", {16'h0, ts_data}, 0);
    check("t6_rst_count", {16'h0, match_count}, 0);
    check("t6_rst_full", {31'h0, fifo_full}, 0);
    tick();
    nrst = 1'b1;
    cyc  = 0;
    tick();
    check("t6_post_valid", {31'h0, ts_valid}, 0);
    pulse(2);
    check("t6_ts_restart", {16'h0, ts_data}, 2);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule

// File: doc/match_event_logger.md
MATCH_EVENT_LOGGER -- requirements
Module: match_event_logger

Interface
REQ-001 SHALL have parameter DEPTH, default 4, timestamp FIFO depth, power of two, 2..16.
REQ-002 SHALL have parameter TS_W, default 16, timestamp width.
REQ-003 SHALL have parameter CNT_W, default 16, match counter width.
REQ-004 SHALL have port clk  input  1  rising-edge clock.
REQ-005 SHALL have port nrst  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port match_in  input  1  match flag from upstream sequence detector (one-cycle high per match).
REQ-007 SHALL have port clr  input  1  synchronous clear of count, FIFO, alarm, overflow.
REQ-008 SHALL have port threshold  input  CNT_W  alarm threshold; 0 disables alarm.
REQ-009 SHALL have port rd_en  input  1  pop FIFO head.
REQ-010 SHALL have port ts_data  output  TS_W  FIFO head timestamp, valid when ts_valid=1.
REQ-011 SHALL have port ts_valid  output  1  FIFO non-empty.
REQ-012 SHALL have port fifo_full  output  1  FIFO holds DEPTH entries.
REQ-013 SHALL have port match_count  output  CNT_W  saturating event count.
REQ-014 SHALL have port alarm  output  1  count reached threshold.
REQ-015 SHALL have port overflow  output  1  sticky: event dropped because FIFO full.

Function
REQ-016 SHALL register match_in into match_d (reset 0); event = match_in & ~match_d (rising edge), so a held-high input counts once.
REQ-017 SHALL run a free-running TS_W cycle counter, +1 every clock, wrapping max->0, unaffected by clr.
REQ-018 SHALL, on event in cycle N, increment match_count at edge N, visible cycle N+1; saturate at all-ones.
REQ-019 SHALL, on event, push the timestamp counter value sampled in cycle N into FIFO; entry visible on ts_data no earlier than N+1.
REQ-020 SHALL present FIFO head combinationally on ts_data (show-ahead); ts_data = 0 when empty.
REQ-021 SHALL pop on rd_en & ts_valid; rd_en when empty ignored, no underflow.
REQ-022 SHALL, on push while full without pop, drop the event timestamp, set overflow; match_count still increments.
REQ-023 SHALL, on simultaneous push and pop when full, perform both; occupancy unchanged, overflow not set.
REQ-024 SHALL, on simultaneous push and pop when empty, perform push only; ts_valid=1 next cycle.
REQ-025 SHALL use wrapping read/write pointers of log2(DEPTH)+1 bits; full/empty from pointer compare.
REQ-026 SHALL register alarm: set when threshold!=0 and next match_count >= threshold; stays set until clr or reset, even if threshold changes.
REQ-027 SHALL, on clr, empty FIFO, zero match_count, clear alarm and overflow at that edge; clr wins over same-cycle event and rd_en (event discarded, not counted).

Reset
REQ-028 SHALL on nrst=0 asynchronously set match_d=0, timestamp=0, match_count=0, FIFO empty, ts_valid=0, fifo_full=0, alarm=0, overflow=0, ts_data=0.
REQ-029 SHALL, on reset mid-operation, discard all FIFO contents; first edge after release behaves as post-reset cycle 0.

Structure
REQ-030 SHALL place DEPTH, TS_W, CNT_W defaults and pointer-width function in shared package match_log_pkg.
REQ-031 SHALL implement FIFO as sub-module ts_fifo (push, pop, din, dout, empty, full, clr); edge detect, counters, alarm in top.

Verification
REQ-032 SHALL test: reset, match_in pulses at cycles 5,9,13 -> match_count=3, ts_data pops 5,9,13 in order.
REQ-033 SHALL test: match_in held high 10 cycles -> match_count=1, one FIFO entry.
REQ-034 SHALL test: 6 events, no reads, DEPTH=4 -> fifo_full=1, overflow=1, match_count=6, pops return first 4 timestamps.
REQ-035 SHALL test: FIFO full, event and rd_en same cycle -> oldest popped, new stored, overflow stays 0.
REQ-036 SHALL test: threshold=3, 3 events -> alarm=1 cycle after 3rd event; clr with event same cycle -> count 0, alarm 0, FIFO empty.
REQ-037 SHALL test: nrst asserted with 2 entries queued -> all outputs 0 immediately, ts_valid=0 after release.
